// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit active-low seven-segment bus.
// Each settled digit dwell is decoded to BCD; a full frame is published with a one-cycle strobe.
module seg_scan_decoder #(
    parameter int unsigned SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] o_val,
    output logic        o_valid,
    output logic [3:0]  o_blank,
    output logic        o_err
);

    localparam logic [10:0] IDLE      = {4'hF, 7'h7F};
    localparam logic [7:0]  SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0]  SETTLE_M1 = 8'(SETTLE - 1);

    logic [10:0] x;
    logic [10:0] x_prev;
    logic [7:0]  cnt;
    logic [15:0] dig;
    logic [3:0]  blk;
    logic [3:0]  seen;

    logic [3:0]  nib;
    logic        is_blank;
    logic        pat_ok;
    logic [1:0]  sel;
    logic        an_ok;
    logic        capture;
    logic [3:0]  onehot;
    logic [15:0] new_dig;
    logic [3:0]  new_blk;

    always_comb begin
        nib      = 4'd0;
        is_blank = 1'b0;
        pat_ok   = 1'b1;
        case (x[6:0])
            7'h40: nib = 4'd0;
            7'h79: nib = 4'd1;
            7'h24: nib = 4'd2;
            7'h30: nib = 4'd3;
            7'h19: nib = 4'd4;
            7'h12: nib = 4'd5;
            7'h02: nib = 4'd6;
            7'h78: nib = 4'd7;
            7'h00: nib = 4'd8;
            7'h10: nib = 4'd9;
            7'h7F: is_blank = 1'b1;
            default: pat_ok = 1'b0;
        endcase
    end

    // Only a single active anode names a digit; blink (F) and ghost codes are ignored.
    always_comb begin
        sel   = 2'd0;
        an_ok = 1'b1;
        case (x[10:7])
            4'hE: sel = 2'd0;
            4'hD: sel = 2'd1;
            4'hB: sel = 2'd2;
            4'h7: sel = 2'd3;
            default: an_ok = 1'b0;
        endcase
    end

    assign capture = (x == x_prev) && (cnt == SETTLE_M1) && an_ok;
    assign onehot  = 4'b0001 << sel;

    always_comb begin
        new_dig = dig;
        new_dig[{sel, 2'b00} +: 4] = nib;
        new_blk = blk;
        new_blk[sel] = is_blank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= IDLE;
            x_prev  <= IDLE;
            cnt     <= '0;
            dig     <= '0;
            blk     <= '0;
            seen    <= '0;
            o_val   <= '0;
            o_blank <= '0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            x       <= {an, seg};
            x_prev  <= x;
            o_valid <= 1'b0;
            o_err   <= 1'b0;

            if (x != x_prev)
                cnt <= '0;
            else if (cnt != SETTLE_C)
                cnt <= cnt + 8'd1;

            if (capture) begin
                if (pat_ok) begin
                    dig <= new_dig;
                    blk <= new_blk;
                    if ((seen | onehot) == 4'hF) begin
                        o_val   <= new_dig;
                        o_blank <= new_blk;
                        o_valid <= 1'b1;
                        seen    <= '0;
                    end else begin
                        seen <= seen | onehot;
                    end
                end else begin
                    o_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE=4; inputs change on the falling edge,
// outputs are observed on the falling edge after each rising edge.
module tb_seg_scan_decoder;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] o_val;
    logic        o_valid;
    logic [3:0]  o_blank;
    logic        o_err;

    int errors = 0;
    int checks = 0;

    int valid_count;
    int err_count;
    int valid_edge;

    seg_scan_decoder #(.SETTLE(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (seg),
        .an      (an),
        .o_val   (o_val),
        .o_valid (o_valid),
        .o_blank (o_blank),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold one pattern for n rising edges, tallying strobes seen after each edge.
    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_valid === 1'b1) begin
                valid_count++;
                valid_edge = k;
            end
            if (o_err === 1'b1) err_count++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        valid_count = 0;
        err_count   = 0;
        valid_edge  = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        an  = 4'b1110;
        seg = 7'h00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (o_val !== 16'h0000) begin errors++; $display("FAIL reset_o_val got=%h want=0000", o_val); end
            checks++; if (o_blank !== 4'h0) begin errors++; $display("FAIL reset_o_blank got=%b want=0000", o_blank); end
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b want=0", o_valid); end
            checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_o_err got=%b want=0", o_err); end
        end
        rst = 1'b0;
        valid_count = 0;
        err_count   = 0;
        dwell(4'hF, 7'h7F, 8);
        checks++; if (valid_count !== 0) begin errors++; $display("FAIL post_reset_valid got=%0d want=0", valid_count); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL post_reset_err got=%0d want=0", err_count); end
        checks++; if (o_val !== 16'h0000) begin errors++; $display("FAIL post_reset_o_val got=%h want=0000", o_val); end
    endtask

    task automatic test_normal_frame();
        do_reset();
        dwell(4'hE, 7'h79, 8);
        dwell(4'hD, 7'h24, 8);
        dwell(4'hB, 7'h30, 8);
        checks++; if (valid_count !== 0) begin errors++; $display("FAIL normal_early_valid got=%0d want=0", valid_count); end
        dwell(4'h7, 7'h19, 8);
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL normal_valid_count got=%0d want=1", valid_count); end
        checks++; if (valid_edge !== 6) begin errors++; $display("FAIL normal_valid_edge got=%0d want=6", valid_edge); end
        checks++; if (o_val !== 16'h4321) begin errors++; $display("FAIL normal_o_val got=%h want=4321", o_val); end
        checks++; if (o_blank !== 4'b0000) begin errors++; $display("FAIL normal_o_blank got=%b want=0000", o_blank); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL normal_err got=%0d want=0", err_count); end
        dwell(4'hF, 7'h7F, 10);
        checks++; if (o_val !== 16'h4321) begin errors++; $display("FAIL normal_hold_o_val got=%h want=4321", o_val); end
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL normal_hold_valid got=%0d want=1", valid_count); end
    endtask

    task automatic test_dwell_boundary();
        do_reset();
        dwell(4'hE, 7'h79, 4);
        dwell(4'hF, 7'h7F, 3);
        dwell(4'hD, 7'h24, 8);
        dwell(4'hB, 7'h30, 8);
        dwell(4'h7, 7'h19, 8);
        dwell(4'hF, 7'h7F, 3);
        checks++; if (valid_count !== 0) begin errors++; $display("FAIL short_dwell_valid got=%0d want=0", valid_count); end
        dwell(4'hE, 7'h79, 5);
        dwell(4'hF, 7'h7F, 3);
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL min_dwell_valid got=%0d want=1", valid_count); end
        checks++; if (o_val !== 16'h4321) begin errors++; $display("FAIL min_dwell_o_val got=%h want=4321", o_val); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL dwell_err got=%0d want=0", err_count); end
    endtask

    task automatic test_blank_digit();
        do_reset();
        dwell(4'hE, 7'h79, 8);
        dwell(4'hD, 7'h24, 8);
        dwell(4'hB, 7'h30, 8);
        dwell(4'h7, 7'h7F, 8);
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL blank_valid got=%0d want=1", valid_count); end
        checks++; if (o_val !== 16'h0321) begin errors++; $display("FAIL blank_o_val got=%h want=0321", o_val); end
        checks++; if (o_blank !== 4'b1000) begin errors++; $display("FAIL blank_o_blank got=%b want=1000", o_blank); end
    endtask

    task automatic test_undecodable();
        do_reset();
        dwell(4'hE, 7'h79, 8);
        dwell(4'hD, 7'h7E, 8);
        checks++; if (err_count !== 1) begin errors++; $display("FAIL undec_err got=%0d want=1", err_count); end
        dwell(4'hB, 7'h30, 8);
        dwell(4'h7, 7'h19, 8);
        checks++; if (valid_count !== 0) begin errors++; $display("FAIL undec_no_valid got=%0d want=0", valid_count); end
        dwell(4'hD, 7'h24, 8);
        checks++; if (valid_count !== 1) begin errors++; $display("FAIL undec_rescan_valid got=%0d want=1", valid_count); end
        checks++; if (o_val !== 16'h4321) begin errors++; $display("FAIL undec_o_val got=%h want=4321", o_val); end
        checks++; if (err_count !== 1) begin errors++; $display("FAIL undec_err_total got=%0d want=1", err_count); end
    endtask

    task automatic test_blink_illegal();
        do_reset();
        dwell(4'hF, 7'h7E, 100);
        dwell(4'b1100, 7'h7E, 20);
        dwell(4'b1100, 7'h79, 20);
        checks++; if (valid_count !== 0) begin errors++; $display("FAIL blink_valid got=%0d want=0", valid_count); end
        checks++; if (err_count !== 0) begin errors++; $display("FAIL blink_err got=%0d want=0", err_count); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        dwell(4'hE, 7'h79, 8);
        dwell(4'hD, 7'h24, 8);
        dwell(4'hB, 7'h30, 8);
        dwell(4'h7, 7'h19, 8);
        dwell(4'hE, 7'h12, 8);
        dwell(4'hD, 7'h02, 8);
        dwell(4'hB, 7'h78, 8);
        do_reset();
        checks++; if (o_val !== 16'h0000) begin errors++; $display("FAIL midreset_o_val got=%h want=0000", o_val); end
        dwell(4'h7, 7'h00, 8);
        dwell(4'hF, 7'h7F, 8);
        checks++; if (valid_count !== 0) begin errors++; $display("FAIL midreset_valid got=%0d want=0", valid_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        dwell(4'hE, 7'h79, 5);
        dwell(4'hD, 7'h24, 5);
        dwell(4'hB, 7'h30, 5);
        dwell(4'h7, 7'h19, 5);
        dwell(4'hE, 7'h00, 5);
        checks++; if (o_val !== 16'h4321) begin errors++; $display("FAIL b2b_first_o_val got=%h want=4321", o_val); end
        dwell(4'hD, 7'h10, 5);
        dwell(4'hB, 7'h40, 5);
        dwell(4'h7, 7'h79, 5);
        dwell(4'hF, 7'h7F, 4);
        checks++; if (valid_count !== 2) begin errors++; $display("FAIL b2b_valid got=%0d want=2", valid_count); end
        checks++; if (o_val !== 16'h1098) begin errors++; $display("FAIL b2b_o_val got=%h want=1098", o_val); end
        checks++; if (o_blank !== 4'b0000) begin errors++; $display("FAIL b2b_o_blank got=%b want=0000", o_blank); end
    endtask

    initial begin
        rst = 1'b1;
        an  = 4'hF;
        seg = 7'h7F;
        valid_count = 0;
        err_count   = 0;
        valid_edge  = -1;
        test_reset();
        test_normal_frame();
        test_dwell_boundary();
        test_blank_digit();
        test_undecodable();
        test_blink_illegal();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
